filter_sequencer: RTL
=====================

# filter_sequencer

Controller that sequences the intensity → edgedetect → mean_average cartoon-filter datapath one 3x3 window at a time. It accepts windows over a valid/ready handshake and tracks image row/column. Border pixels bypass the filter. For interior pixels it drives `pixelData` to the datapath, pulses `intensity_enable`, waits for `pixel_done`, and presents the filtered pixel on an output valid/ready port.

## Interface
- `IMG_WIDTH`, default 640, pixels per row (≥3)
- `IMG_HEIGHT`, default 480, rows per image (≥3)
- `TIMEOUT_CYCLES`, default 15, maximum WAIT cycles before bypass
- `clk`  in  1  system clock
- `n_rst`  in  1  asynchronous active-low reset
- `start`  in  1  begin new image; honored only in IDLE
- `frame_valid`  in  1  window available
- `frame_data`  in  216  3x3 window, row-major, pixel (r-1,c-1) at [215:192]; center at [119:96]
- `frame_ready`  out  1  sequencer accepts window
- `pixelData`  out  216  window to intensity and mean_average
- `intensity_enable`  out  1  one-cycle launch pulse
- `pixel_done`  in  1  mean_average result strobe
- `f_pixel`  in  24  mean_average result
- `out_valid`  out  1  result available
- `out_pixel`  out  24  result pixel
- `out_ready`  in  1  consumer accepts result
- `out_row`, `out_col`  out  16 each  position of `out_pixel`
- `image_done`  out  1  one-cycle pulse on the last pixel handshake
- `timeout_err`  out  1  sticky; set on any timeout; cleared by an accepted `start`

## Operation
- States: IDLE, FETCH, LAUNCH, WAIT, EMIT.
- **IDLE → FETCH on `start`:** row=col=0, `timeout_err` cleared.
- **FETCH:** `frame_ready`=1. On `frame_valid`&`frame_ready`, register `frame_data` into `pixelData`.
  - Border position (row==0, row==IMG_HEIGHT-1, col==0, or col==IMG_WIDTH-1): result = center pixel, go to EMIT.
  - Otherwise go to LAUNCH.
- **LAUNCH:** `intensity_enable`=1 for exactly this cycle, then WAIT. Clear the wait counter.
- **WAIT:** counter increments each cycle.
  - On `pixel_done`: latch `f_pixel`, go to EMIT.
  - When counter == TIMEOUT_CYCLES-1 without `pixel_done`: result = center pixel, set `timeout_err`, go to EMIT.
  - `pixel_done` in the same cycle as the timeout wins; no error is flagged.
- **EMIT:** `out_valid`=1. `out_pixel`, `out_row`, `out_col` are held until `out_valid`&`out_ready`. On that handshake:
  - Advance col; wrap to 0 at IMG_WIDTH-1 and increment row.
  - If the pixel was (IMG_HEIGHT-1, IMG_WIDTH-1): pulse `image_done`, go to IDLE. Otherwise go to FETCH.
- `pixelData` stays stable from capture until the next capture; it is never changed in LAUNCH, WAIT, or EMIT.
- Ignored inputs:
  - `pixel_done` outside WAIT.
  - `start` outside IDLE.
  - `frame_valid` outside FETCH.
- Counters: row/col are 16 bits; wait counter is $clog2(TIMEOUT_CYCLES+1) bits. No arithmetic on pixel data.

## Timing
- Reset (async, any state): state=IDLE; all outputs 0, including `pixelData`, `out_pixel`, row/col, and `timeout_err`. An in-flight result is discarded.
- All outputs are registered except `frame_ready` and `out_valid`, which are decoded from state.
- Border pixel: window accepted at edge N → `out_valid` high in cycle N+1.
- Interior pixel: accept at edge N → `intensity_enable` high in cycle N+1 (LAUNCH) → `pixel_done` seen at edge M → `out_valid` high in cycle M+1.
- Throughput: at most one window per 2 cycles (border) or per 3+datapath latency cycles (interior).
- `image_done` is asserted in the cycle after the final handshake, for one cycle.
- No combinational path from `out_ready` to `frame_ready`.

## Structure
- `filter_pkg`: state enum `seq_state_t`; `PIXEL_W`=24, `FRAME_W`=216, `CENTER_LSB`=96.
- Sub-module `pixel_position_counter`: row/col registers with enable, clear, wrap, `is_border` and `is_last` outputs.
- FSM, wait counter, and output registers live in `filter_sequencer`.

## Test plan
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=3, TIMEOUT_CYCLES=15, and a mock mean_average.
- **Reset:** assert `n_rst`=0 mid-WAIT → all outputs 0 asynchronously, state IDLE, no `out_valid` after release.
- **Border bypass:** `start`, then window with center 0x112233 at (0,0) → `out_pixel`=0x112233, `out_row`=0, `out_col`=0, `out_valid` one cycle after accept, `intensity_enable` never high.
- **Interior:** at (1,1), mock returns `pixel_done` with `f_pixel`=0xABCDEF 4 cycles after the enable → exactly one `intensity_enable` pulse, `out_pixel`=0xABCDEF, `pixelData` unchanged throughout.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in EMIT → `out_valid`=1 and `out_pixel`/`out_row`/`out_col` stable, `frame_ready`=0.
- **Timeout:** no `pixel_done` at (1,2) with center 0x445566 → after 15 WAIT cycles `out_pixel`=0x445566, `timeout_err`=1 held until the next `start`.
- **Full image:** 12 windows with random `out_ready` → outputs in raster order, 2 interior launches, single `image_done` pulse after (2,3), return to IDLE; `start` during WAIT ignored.

Source files
------------

// File: rtl/filter_pkg.sv
// filter_pkg: shared types and widths for the cartoon-filter sequencer.
// Sequencer state encoding, pixel/window widths, center-pixel helper.
package filter_pkg;

  localparam int PIXEL_W    = 24;
  localparam int FRAME_W    = 216;
  localparam int CENTER_LSB = 96;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4
  } seq_state_t;

  function automatic logic [PIXEL_W-1:0] center_of(
    input logic [FRAME_W-1:0] w
  );
    return w[CENTER_LSB +: PIXEL_W];
  endfunction

endpackage

// File: rtl/filter_sequencer_position.sv
// pixel_position_counter: raster row/col tracker for the sequencer.
// Ports: clk, n_rst, clr, adv in; row, col, is_border, is_last out.
module pixel_position_counter #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clr,
  input  logic        adv,
  output logic [15:0] row,
  output logic [15:0] col,
  output logic        is_border,
  output logic        is_last
);

  localparam logic [15:0] COL_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMG_HEIGHT - 1);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  assign is_border = (row == '0) || (row == ROW_LAST) ||
                     (col == '0) || (col == COL_LAST);
  assign is_last   = (row == ROW_LAST) && (col == COL_LAST);

endmodule

// File: rtl/filter_sequencer.sv
// filter_sequencer: steps 3x3 windows through the filter datapath.
// Ports: frame in (valid/ready), datapath launch/done, result out.
module filter_sequencer
  import filter_pkg::*;
#(
  parameter int IMG_WIDTH      = 640,
  parameter int IMG_HEIGHT     = 480,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame_data,
  output logic               frame_ready,
  output logic [FRAME_W-1:0] pixelData,
  output logic               intensity_enable,
  input  logic               pixel_done,
  input  logic [PIXEL_W-1:0] f_pixel,
  output logic               out_valid,
  output logic [PIXEL_W-1:0] out_pixel,
  input  logic               out_ready,
  output logic [15:0]        out_row,
  output logic [15:0]        out_col,
  output logic               image_done,
  output logic               timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

  seq_state_t    state;
  logic [CW-1:0] wait_cnt;
  logic [15:0]   row;
  logic [15:0]   col;
  logic          is_border;
  logic          is_last;
  logic          pos_clr;
  logic          pos_adv;

  assign frame_ready = (state == S_FETCH);
  assign out_valid   = (state == S_EMIT);
  assign pos_clr     = (state == S_IDLE) && start;
  assign pos_adv     = (state == S_EMIT) && out_ready;

  pixel_position_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_pos (
    .clk      (clk),
    .n_rst    (n_rst),
    .clr      (pos_clr),
    .adv      (pos_adv),
    .row      (row),
    .col      (col),
    .is_border(is_border),
    .is_last  (is_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state            <= S_IDLE;
      wait_cnt         <= '0;
      pixelData        <= '0;
      intensity_enable <= 1'b0;
      out_pixel        <= '0;
      out_row          <= '0;
      out_col          <= '0;
      image_done       <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      intensity_enable <= 1'b0;
      image_done       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            timeout_err <= 1'b0;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (frame_valid) begin
            pixelData <= frame_data;
            out_row   <= row;
            out_col   <= col;
            if (is_border) begin
              out_pixel <= center_of(frame_data);
              state     <= S_EMIT;
            end else begin
              intensity_enable <= 1'b1;
              state            <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // a done strobe on the timeout cycle still counts as success
          if (pixel_done) begin
            out_pixel <= f_pixel;
            state     <= S_EMIT;
          end else if (wait_cnt == WAIT_LAST) begin
            out_pixel   <= center_of(pixelData);
            timeout_err <= 1'b1;
            state       <= S_EMIT;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            image_done <= is_last;
            state      <= is_last ? S_IDLE : S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
